// File: rtl/ram32x4_arbiter_if.sv
// Signal bundle linking requesters A/B, the arbiter and the ram32x4 instance.
// The arbiter uses the slave view; the surrounding logic uses the master view.
interface ram32x4_arbiter_if;
    logic       a_req;
    logic       a_wren;
    logic [4:0] a_addr;
    logic [3:0] a_data;
    logic       a_gnt;
    logic       a_rvalid;
    logic [3:0] a_q;

    logic       b_req;
    logic       b_wren;
    logic [4:0] b_addr;
    logic [3:0] b_data;
    logic       b_gnt;
    logic       b_rvalid;
    logic [3:0] b_q;

    logic       init_done;
    logic [4:0] ram_address;
    logic [3:0] ram_data;
    logic       ram_wren;
    logic [3:0] ram_q;

    modport slave (
        input  a_req, a_wren, a_addr, a_data,
        input  b_req, b_wren, b_addr, b_data,
        input  ram_q,
        output a_gnt, a_rvalid, a_q,
        output b_gnt, b_rvalid, b_q,
        output init_done, ram_address, ram_data, ram_wren
    );

    modport master (
        output a_req, a_wren, a_addr, a_data,
        output b_req, b_wren, b_addr, b_data,
        output ram_q,
        input  a_gnt, a_rvalid, a_q,
        input  b_gnt, b_rvalid, b_q,
        input  init_done, ram_address, ram_data, ram_wren
    );
endinterface

// File: rtl/ram32x4_arbiter.sv
// Shares a single-port ram32x4 between requesters A and B: init sweep after reset,
// then one round-robin access per clock with read data steered back by a tag pipeline.
module ram32x4_arbiter #(
    parameter int         READ_LATENCY = 2,
    parameter bit         INIT_ENABLE  = 1'b1,
    parameter logic [3:0] INIT_VALUE   = 4'h0
) (
    input  logic             clk,
    input  logic             reset,
    ram32x4_arbiter_if.slave bus
);

    typedef enum logic {S_INIT, S_ARB} state_t;

    state_t                  r_state;
    logic [4:0]              r_init_addr;
    logic                    r_init_done;
    logic                    r_last_b;
    logic [READ_LATENCY-1:0] r_tag_vld_p;
    logic [READ_LATENCY-1:0] r_tag_id_p;

    logic                    w_a_gnt;
    logic                    w_b_gnt;
    logic                    w_rd_accept;
    logic                    w_ram_wren;
    logic [4:0]              w_ram_address;
    logic [3:0]              w_ram_data;

    // Ties go to whoever was not served last; a lone requester always wins.
    always_comb begin
        w_a_gnt = 1'b0;
        w_b_gnt = 1'b0;
        if (r_state == S_ARB) begin
            if (bus.a_req && (!bus.b_req || r_last_b)) begin
                w_a_gnt = 1'b1;
            end else if (bus.b_req) begin
                w_b_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        w_ram_wren    = 1'b0;
        w_ram_address = 5'd0;
        w_ram_data    = 4'h0;
        if (r_state == S_INIT) begin
            w_ram_wren    = 1'b1;
            w_ram_address = r_init_addr;
            w_ram_data    = INIT_VALUE;
        end else if (w_a_gnt) begin
            w_ram_wren    = bus.a_wren;
            w_ram_address = bus.a_addr;
            w_ram_data    = bus.a_data;
        end else if (w_b_gnt) begin
            w_ram_wren    = bus.b_wren;
            w_ram_address = bus.b_addr;
            w_ram_data    = bus.b_data;
        end
    end

    assign w_rd_accept = (w_a_gnt & ~bus.a_wren) | (w_b_gnt & ~bus.b_wren);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= INIT_ENABLE ? S_INIT : S_ARB;
            r_init_addr <= 5'd0;
            r_init_done <= !INIT_ENABLE;
            r_last_b    <= 1'b1;
            r_tag_vld_p <= '0;
            r_tag_id_p  <= '0;
        end else begin
            case (r_state)
                S_INIT: begin
                    r_init_addr <= r_init_addr + 5'd1;
                    if (r_init_addr == 5'd31) begin
                        r_state     <= S_ARB;
                        r_init_done <= 1'b1;
                    end
                end
                S_ARB: begin
                    if (w_a_gnt || w_b_gnt) begin
                        r_last_b <= w_b_gnt;
                    end
                end
                default: r_state <= S_ARB;
            endcase

            // Tag id 1 marks a read issued by B; the last stage lines up with ram_q.
            r_tag_vld_p[0] <= w_rd_accept;
            r_tag_id_p[0]  <= w_b_gnt;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_tag_vld_p[i] <= r_tag_vld_p[i-1];
                r_tag_id_p[i]  <= r_tag_id_p[i-1];
            end
        end
    end

    assign bus.a_gnt       = w_a_gnt;
    assign bus.b_gnt       = w_b_gnt;
    assign bus.a_rvalid    = r_tag_vld_p[READ_LATENCY-1] & ~r_tag_id_p[READ_LATENCY-1];
    assign bus.b_rvalid    = r_tag_vld_p[READ_LATENCY-1] &  r_tag_id_p[READ_LATENCY-1];
    assign bus.a_q         = bus.ram_q;
    assign bus.b_q         = bus.ram_q;
    assign bus.init_done   = r_init_done;
    assign bus.ram_wren    = w_ram_wren;
    assign bus.ram_address = w_ram_address;
    assign bus.ram_data    = w_ram_data;

endmodule

// File: tb/tb_ram32x4_arbiter.sv
// Bench for ram32x4_arbiter: behavioural ram32x4 (registered address and q),
// directed stimulus with a queue-based scoreboard for read responses.
module tb_ram32x4_arbiter;
    localparam int RL = 2;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   failures;

    ram32x4_arbiter_if bus ();

    ram32x4_arbiter #(
        .READ_LATENCY(RL),
        .INIT_ENABLE (1'b1),
        .INIT_VALUE  (4'h0)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // ram32x4 model: address registered on the edge, q registered one edge later
    logic [3:0] mem [32];
    logic [4:0] m_addr;
    logic [3:0] m_q;
    always @(posedge clk) begin
        if (bus.ram_wren) mem[bus.ram_address] <= bus.ram_data;
        m_addr <= bus.ram_address;
        m_q    <= mem[m_addr];
    end
    assign bus.ram_q = m_q;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    typedef struct {
        logic       id;
        logic [3:0] q;
        int         cyc;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Response monitor: pops one expectation per rvalid cycle.
    always @(negedge clk) begin
        exp_t e;
        if (bus.a_rvalid || bus.b_rvalid) begin
            chk("rvalid_onehot", {31'd0, bus.a_rvalid & bus.b_rvalid}, 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rvalid_unexpected actual a=%0b b=%0b required none", bus.a_rvalid, bus.b_rvalid);
            end else begin
                e = exp_q.pop_front();
                chk("rd_id", {31'd0, bus.b_rvalid}, {31'd0, e.id});
                chk("rd_data", {28'd0, (bus.a_rvalid ? bus.a_q : bus.b_q)}, {28'd0, e.q});
                chk("rd_cycle", cyc, e.cyc);
            end
        end
    end

    // Called at a negedge: drive one cycle of requests, check grants, log expected reads.
    task automatic acc(input string nm,
                       input logic ar, input logic aw, input logic [4:0] aa, input logic [3:0] ad,
                       input logic br, input logic bw, input logic [4:0] ba, input logic [3:0] bd,
                       input logic ega, input logic egb, input logic [3:0] eq);
        exp_t e;
        bus.a_req = ar; bus.a_wren = aw; bus.a_addr = aa; bus.a_data = ad;
        bus.b_req = br; bus.b_wren = bw; bus.b_addr = ba; bus.b_data = bd;
        #1;
        chk({nm, "_a_gnt"}, {31'd0, bus.a_gnt}, {31'd0, ega});
        chk({nm, "_b_gnt"}, {31'd0, bus.b_gnt}, {31'd0, egb});
        if ((ega && !aw) || (egb && !bw)) begin
            e.id  = egb;
            e.q   = eq;
            e.cyc = cyc + RL;
            exp_q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
        bus.a_wren = 1'b0;
        bus.b_wren = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Called at the negedge where the sweep starts; ends at the first ARB negedge.
    task automatic init_sweep(input string nm);
        for (int k = 0; k < 32; k++) begin
            #1;
            chk({nm, "_wren"}, {31'd0, bus.ram_wren}, 32'd1);
            chk({nm, "_addr"}, {27'd0, bus.ram_address}, k);
            chk({nm, "_done"}, {31'd0, bus.init_done}, 32'd0);
            chk({nm, "_a_gnt"}, {31'd0, bus.a_gnt}, 32'd0);
            @(negedge clk);
        end
        #1;
        chk({nm, "_done_end"}, {31'd0, bus.init_done}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc = 0; checks = 0; failures = 0;
        reset = 1'b0;
        bus.a_req = 1'b0; bus.a_wren = 1'b0; bus.a_addr = 5'd0; bus.a_data = 4'h0;
        bus.b_req = 1'b0; bus.b_wren = 1'b0; bus.b_addr = 5'd0; bus.b_data = 4'h0;

        @(negedge clk);
        #1;
        chk("rst_init_done", {31'd0, bus.init_done}, 32'd0);
        chk("rst_a_rvalid", {31'd0, bus.a_rvalid}, 32'd0);
        chk("rst_b_rvalid", {31'd0, bus.b_rvalid}, 32'd0);
        chk("rst_addr", {27'd0, bus.ram_address}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // 1: init sweep, then A reads address 7
        init_sweep("t1_init");
        chk("t1_idle_wren", {31'd0, bus.ram_wren}, 32'd0);
        acc("t1_rd7", 1'b1, 1'b0, 5'd7, 4'h0, 1'b0, 1'b0, 5'd0, 4'h0, 1'b1, 1'b0, 4'h0);
        idle(3);

        // 2: A writes 0x0A, B reads it back next cycle
        bus.a_req = 1'b1; bus.a_wren = 1'b1; bus.a_addr = 5'h0A; bus.a_data = 4'hA;
        #1;
        chk("t2_ram_wren", {31'd0, bus.ram_wren}, 32'd1);
        chk("t2_ram_addr", {27'd0, bus.ram_address}, 32'h0A);
        chk("t2_ram_data", {28'd0, bus.ram_data}, 32'hA);
        @(negedge clk);
        acc("t2_rd", 1'b0, 1'b0, 5'd0, 4'h0, 1'b1, 1'b0, 5'h0A, 4'h0, 1'b0, 1'b1, 4'hA);
        idle(3);

        // 3: seed words 1/2, then both requesters contend for 4 cycles
        acc("t3_wa", 1'b1, 1'b1, 5'h01, 4'h3, 1'b0, 1'b0, 5'd0, 4'h0, 1'b1, 1'b0, 4'h0);
        acc("t3_wb", 1'b0, 1'b0, 5'd0, 4'h0, 1'b1, 1'b1, 5'h02, 4'h5, 1'b0, 1'b1, 4'h0);
        acc("t3_c0", 1'b1, 1'b0, 5'h01, 4'h0, 1'b1, 1'b0, 5'h02, 4'h0, 1'b1, 1'b0, 4'h3);
        acc("t3_c1", 1'b1, 1'b0, 5'h01, 4'h0, 1'b1, 1'b0, 5'h02, 4'h0, 1'b0, 1'b1, 4'h5);
        acc("t3_c2", 1'b1, 1'b0, 5'h01, 4'h0, 1'b1, 1'b0, 5'h02, 4'h0, 1'b1, 1'b0, 4'h3);
        acc("t3_c3", 1'b1, 1'b0, 5'h01, 4'h0, 1'b1, 1'b0, 5'h02, 4'h0, 1'b0, 1'b1, 4'h5);
        idle(3);

        // 4: B alone for 3 cycles
        for (int i = 0; i < 3; i++) begin
            acc("t4_b", 1'b0, 1'b0, 5'd0, 4'h0, 1'b1, 1'b0, 5'h02, 4'h0, 1'b0, 1'b1, 4'h5);
        end
        idle(3);

        // 5/6: read in flight killed by reset; A then waits through the new sweep
        acc("t5_rd", 1'b1, 1'b0, 5'h0A, 4'h0, 1'b0, 1'b0, 5'd0, 4'h0, 1'b1, 1'b0, 4'hA);
        bus.a_req = 1'b0;
        reset = 1'b0;
        exp_q.delete();
        #1;
        chk("t5_rst_done", {31'd0, bus.init_done}, 32'd0);
        chk("t5_rst_a_rvalid", {31'd0, bus.a_rvalid}, 32'd0);
        @(negedge clk);
        #1;
        chk("t5_rst_addr", {27'd0, bus.ram_address}, 32'd0);
        chk("t5_rst_a_rvalid2", {31'd0, bus.a_rvalid}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        bus.a_req = 1'b1; bus.a_wren = 1'b0; bus.a_addr = 5'h0A;
        init_sweep("t6_init");
        acc("t6_first_arb", 1'b1, 1'b0, 5'h0A, 4'h0, 1'b0, 1'b0, 5'd0, 4'h0, 1'b1, 1'b0, 4'h0);
        idle(4);

        chk("sb_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
